mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 11 +
 rtl/mem_access_ctrl_load_extend.sv | 18 +
 rtl/mem_access_ctrl.sv | 119 +++++++++++
 tb/tb_mem_access_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the data-memory access controller.
package mem_ctrl_pkg;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;
endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load result formatting: word pass-through, byte sign- or zero-extension.
module load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_byte,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_data
);
    always_comb begin
        if (!i_byte)
            o_data = i_data;
        else if (i_signed)
            o_data = {{(DATA_W-8){i_data[7]}}, i_data[7:0]};
        else
            o_data = {{(DATA_W-8){1'b0}}, i_data[7:0]};
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Request/response front end for the data memory: checks, holds strobes for
// ACCESS_CYCLES, formats loads and holds the response until consumed.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int MEM_BYTES     = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              memRead,
    output logic              memWrite,
    output logic              byteOperations,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);
    localparam logic [3:0]      CNT_INIT = 4'(ACCESS_CYCLES);
    localparam logic [ADDR_W:0] LIMIT    = (ADDR_W+1)'(MEM_BYTES);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_write, r_byte, r_signed, r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic [ADDR_W:0]     w_end;
    logic                w_err, w_accept, w_last;
    logic [DATA_W-1:0]   w_load;

    // One extra bit so addresses near the top of the 18-bit space cannot wrap.
    assign w_end    = {1'b0, req_addr} + (req_byte ? (ADDR_W+1)'(1) : (ADDR_W+1)'(4));
    assign w_err    = (!req_byte && req_addr[1:0] != 2'b00) || (w_end > LIMIT);
    assign w_accept = req_valid && (r_state == IDLE);
    assign w_last   = (r_state == ACCESS) && (r_cnt == 4'd1);

    load_extend u_load_extend (
        .i_data   (read_data),
        .i_byte   (r_byte),
        .i_signed (r_signed),
        .o_data   (w_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = w_err ? RESP : ACCESS;
            end
            ACCESS: begin
                memRead  = !r_write;
                memWrite = r_write;
                if (r_cnt == 4'd1) w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory-side registers only move on a good accept, so address and
    // write_data keep their last value through errors and idle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_byte   <= 1'b0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            if (w_err) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end else begin
                r_cnt    <= CNT_INIT;
                r_write  <= req_write;
                r_byte   <= req_byte;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= 1'b0;
            end
        end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt - 4'd1;
            if (w_last) r_rdata <= r_write ? '0 : w_load;
        end
    end

    assign byteOperations = r_byte;
    assign address        = r_addr;
    assign write_data     = r_wdata;
    assign resp_rdata     = r_rdata;
    assign resp_err       = r_err;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level memory model.
module tb_mem_access_ctrl;
    localparam int AC = 2;
    localparam int MB = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
    logic [17:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready, resp_valid, resp_err, memRead, memWrite, byteOperations;
    logic [31:0] resp_rdata, write_data, read_data;
    logic [17:0] address;

    logic [7:0]  dmem [MB];   // memory device seen by the DUT
    logic [7:0]  rmem [MB];   // reference contents, updated per transaction
    int          n_cmp = 0, n_err = 0;
    int          ra;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ACCESS_CYCLES(AC), .MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .memRead(memRead),
        .memWrite(memWrite), .byteOperations(byteOperations), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    always_comb begin
        ra = int'(address);
        read_data = {dmem[(ra+3)%MB], dmem[(ra+2)%MB], dmem[(ra+1)%MB], dmem[ra%MB]};
    end

    always @(posedge clk) begin
        if (memWrite) begin
            if (byteOperations) dmem[int'(address)%MB] <= write_data[7:0];
            else for (int i = 0; i < 4; i++) dmem[(int'(address)+i)%MB] <= write_data[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic xact(input bit wr, input bit by, input bit sg,
                        input logic [17:0] addr, input logic [31:0] wd, input int bp);
        int a, strobes, resp_at, k;
        bit exp_err;
        logic [31:0] exp_rd;
        a = int'(addr);
        exp_err = (!by && (a % 4) != 0) || (a + (by ? 1 : 4) > MB);
        exp_rd = 32'h0;
        if (!exp_err && !wr) begin
            if (by) exp_rd = (sg && rmem[a] >= 8'd128) ? 32'(int'(rmem[a]) - 256) : 32'(rmem[a]);
            else    exp_rd = {rmem[a+3], rmem[a+2], rmem[a+1], rmem[a]};
        end

        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_write = wr; req_byte = by; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0; req_write = 1'($urandom); req_byte = 1'($urandom);
        req_signed = 1'($urandom); req_addr = 18'($urandom); req_wdata = $urandom;

        strobes = 0; resp_at = 0; k = 0;
        while (resp_at == 0 && k < 40) begin
            @(negedge clk); k++;
            chk("excl", memRead & memWrite, 0);
            chk("ready_busy", req_ready, 0);
            if (memRead || memWrite) begin
                strobes++;
                chk("strobe_dir", memWrite, wr);
                chk("address", address, addr);
                chk("byteop", byteOperations, by);
                if (wr) chk("write_data", write_data, wd);
            end
            if (resp_valid) resp_at = k;
        end
        chk("resp_latency", resp_at, exp_err ? 1 : AC + 1);
        chk("strobe_cycles", strobes, exp_err ? 0 : AC);
        chk("resp_err", resp_err, exp_err);
        chk("resp_rdata", resp_rdata, exp_rd);

        repeat (bp) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_err", resp_err, exp_err);
            chk("hold_ready", req_ready, 0);
            chk("excl", memRead | memWrite, 0);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        @(negedge clk);
        chk("valid_clear", resp_valid, 0);
        chk("ready_back", req_ready, 1);

        if (!exp_err && wr) begin
            if (by) rmem[a] = wd[7:0];
            else for (int i = 0; i < 4; i++) rmem[a+i] = wd[8*i +: 8];
        end
    endtask

    task automatic reset_mid_store(input logic [17:0] addr, input logic [31:0] wd);
        req_valid = 1; req_write = 1; req_byte = 0; req_signed = 0;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        chk("rst_pre_write", memWrite, 1);
        rst_n = 0; #1;
        chk("rst_write_drop", memWrite, 0);
        chk("rst_read", memRead, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_address", address, 0);
        chk("rst_wdata", write_data, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (AC + 2) begin
            @(negedge clk);
            chk("rst_no_resp", resp_valid, 0);
            chk("rst_ready", req_ready, 1);
            chk("excl", memRead & memWrite, 0);
        end
    endtask

    initial begin
        logic [17:0] addr;
        bit by;
        for (int i = 0; i < MB; i++) begin
            dmem[i] = 8'($urandom);
            rmem[i] = dmem[i];
        end
        repeat (2) @(negedge clk);
        chk("reset_read", memRead, 0);
        chk("reset_write", memWrite, 0);
        chk("reset_byteop", byteOperations, 0);
        chk("reset_address", address, 0);
        chk("reset_wdata", write_data, 0);
        chk("reset_valid", resp_valid, 0);
        chk("reset_rdata", resp_rdata, 0);
        chk("reset_err", resp_err, 0);
        rst_n = 1;
        @(negedge clk);

        xact(1, 0, 0, 18'h10, 32'hDEADBEEF, 0);
        xact(0, 0, 0, 18'h10, 32'h0, 0);
        xact(1, 1, 0, 18'h21, 32'h12345685, 1);
        xact(0, 1, 1, 18'h21, 32'h0, 0);
        xact(0, 1, 0, 18'h21, 32'h0, 0);
        xact(0, 0, 0, 18'h22, 32'h0, 0);
        xact(0, 0, 0, 18'h7E, 32'h0, 0);
        xact(1, 0, 0, 18'h7C, 32'hA5A55A5A, 0);
        xact(0, 0, 0, 18'h7C, 32'h0, 5);
        xact(0, 1, 1, 18'h7F, 32'h0, 0);
        xact(1, 1, 0, 18'h80, 32'hFF, 0);
        xact(0, 0, 0, 18'h3FFFC, 32'h0, 5);

        reset_mid_store(18'h40, 32'h0BADF00D);
        xact(0, 0, 0, 18'h40, 32'h0, 0);

        for (int n = 0; n < 200; n++) begin
            by = 1'($urandom);
            if ($urandom_range(0, 9) == 0) addr = 18'($urandom);
            else addr = 18'($urandom_range(0, MB + 3));
            if (!by && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            xact(1'($urandom), by, 1'($urandom), addr, $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
